// File: rtl/fifo_burst_reader_if.sv
// rtl/fifo_burst_reader_if.sv - FIFO read port and downstream stream bundle for fifo_burst_reader
interface fifo_burst_reader_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_empty;
    logic              fifo_threshold;
    logic              fifo_rd;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    // Reader side: consumes FIFO flags/data and the downstream ready
    modport master (
        input  fifo_data,
        input  fifo_empty,
        input  fifo_threshold,
        input  m_ready,
        output fifo_rd,
        output m_data,
        output m_valid
    );

    // FIFO plus consumer side
    modport slave (
        output fifo_data,
        output fifo_empty,
        output fifo_threshold,
        output m_ready,
        input  fifo_rd,
        input  m_data,
        input  m_valid
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - burst-popping FIFO reader feeding a 2-entry skid buffer stream
module fifo_burst_reader #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 flush,
    fifo_burst_reader_if.master  bus,
    output logic                 busy,
    output logic                 burst_done,
    output logic [CNT_W-1:0]     rd_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [7:0]       BURST_INIT = 8'(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t            state;
    state_t            next_state;
    logic [7:0]        beats_left;
    logic              flush_mode;
    logic [1:0]        occ;
    logic [DATA_W-1:0] buf0;
    logic [DATA_W-1:0] buf1;
    logic              rd_c;
    logic              pop;

    // Oldest skid entry drives the stream; fifo_rd depends only on registers and FIFO flags
    assign bus.m_data  = buf0;
    assign bus.m_valid = (occ != 2'd0);
    assign bus.fifo_rd = rd_c;
    assign pop         = (occ != 2'd0) && bus.m_ready;
    assign busy        = (state != IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and pop strobe
    always_comb begin
        next_state = state;
        rd_c       = 1'b0;
        case (state)
            IDLE: begin
                if (en && !bus.fifo_empty && (bus.fifo_threshold || flush)) begin
                    next_state = BURST;
                end
            end
            BURST: begin
                rd_c = !bus.fifo_empty && (occ < 2'd2) && (flush_mode || (beats_left != 8'd0));
                if (rd_c && !flush_mode && (beats_left == 8'd1)) begin
                    next_state = DRAIN;
                end else if (bus.fifo_empty) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (occ == 2'd0) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Burst bookkeeping: beat budget, flush latch, completion pulse, pop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_left <= 8'd0;
            flush_mode <= 1'b0;
            burst_done <= 1'b0;
            rd_count   <= '0;
        end else begin
            burst_done <= (state == DRAIN) && (next_state == IDLE);
            if ((state == IDLE) && (next_state == BURST)) begin
                beats_left <= BURST_INIT;
                flush_mode <= flush;
            end else if (rd_c && !flush_mode) begin
                beats_left <= beats_left - 8'd1;
            end
            if (rd_c) begin
                rd_count <= rd_count + CNT_ONE;
            end
        end
    end

    // Two-entry skid buffer; buf0 is always the oldest word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ  <= 2'd0;
            buf0 <= '0;
            buf1 <= '0;
        end else begin
            case ({rd_c, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        buf0 <= bus.fifo_data;
                    end else begin
                        buf1 <= bus.fifo_data;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    // A push only happens with occ<2, so a simultaneous pop leaves occ==1
                    buf0 <= bus.fifo_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - directed self-checking bench for fifo_burst_reader
module tb_fifo_burst_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic        burst_done;
    logic [15:0] rd_count;

    fifo_burst_reader_if #(.DATA_W(8)) bus ();

    fifo_burst_reader #(
        .DATA_W(8),
        .BURST_LEN(4),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .flush(flush),
        .bus(bus.master),
        .busy(busy),
        .burst_done(burst_done),
        .rd_count(rd_count)
    );

    always #5 clk = ~clk;

    // FIFO model: first-word-fall-through, pointers wrap at 256
    logic [7:0] mem [256];
    logic [7:0] rd_ptr = 8'd0;
    logic [7:0] wr_ptr = 8'd0;
    assign bus.fifo_data  = mem[rd_ptr];
    assign bus.fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (bus.fifo_rd) rd_ptr <= rd_ptr + 8'd1;
    end

    // Monitor sampled mid-cycle: pops, underflows, stream transfers, done pulses
    int         pop_cnt = 0;
    int         underflow = 0;
    int         done_cnt = 0;
    logic [7:0] rx_q [$];

    always @(negedge clk) begin
        if (bus.fifo_rd) pop_cnt++;
        if (bus.fifo_rd && bus.fifo_empty) underflow++;
        if (bus.m_valid && bus.m_ready) rx_q.push_back(bus.m_data);
        if (burst_done) done_cnt++;
    end

    int n_assert = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fifo_clear();
        wr_ptr = rd_ptr;
    endtask

    task automatic load(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr] = first + 8'(i);
            wr_ptr = wr_ptr + 8'd1;
        end
    endtask

    task automatic wait_done(input string tag);
        int base;
        int k;
        base = done_cnt;
        k = 0;
        while (done_cnt == base && k < 60) begin
            tick();
            k++;
        end
        chk({tag, "_timeout"}, 32'(done_cnt != base), 32'd1);
    endtask

    task automatic chk_rx(input string tag, input int n, input logic [7:0] first);
        chk({tag, "_rx_count"}, 32'(rx_q.size()), 32'(n));
        for (int i = 0; i < n && i < rx_q.size(); i++) begin
            chk({tag, "_rx_data"}, 32'(rx_q[i]), 32'(first) + 32'(i));
        end
    endtask

    initial begin
        int pbase;
        int dbase;

        bus.fifo_threshold = 1'b0;
        bus.m_ready = 1'b0;

        // 1: reset values, then release between edges with en low
        #3;
        chk("rst_fifo_rd", 32'(bus.fifo_rd), 32'd0);
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_m_data", 32'(bus.m_data), 32'd0);
        chk("rst_burst_done", 32'(burst_done), 32'd0);
        chk("rst_rd_count", 32'(rd_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        load(8'h01, 2);
        bus.fifo_threshold = 1'b1;
        #4;
        rst_n = 1'b1;
        tick();
        tick();
        chk("rel_fifo_rd", 32'(bus.fifo_rd), 32'd0);
        chk("rel_busy", 32'(busy), 32'd0);

        // 2: four-beat burst at full throughput
        fifo_clear();
        load(8'h01, 8);
        bus.m_ready = 1'b1;
        rx_q.delete();
        dbase = done_cnt;
        en = 1'b1;
        tick();
        chk("t2_busy", 32'(busy), 32'd1);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_fifo_rd", 32'(bus.fifo_rd), 32'd1);
            tick();
            chk("t2_m_valid", 32'(bus.m_valid), 32'd1);
            chk("t2_m_data", 32'(bus.m_data), 32'(i + 1));
            chk("t2_rd_count", 32'(rd_count), 32'(i + 1));
        end
        chk("t2_rd_stop", 32'(bus.fifo_rd), 32'd0);
        chk("t2_busy_drain", 32'(busy), 32'd1);
        wait_done("t2");
        chk("t2_done_once", 32'(done_cnt - dbase), 32'd1);
        chk("t2_idle", 32'(busy), 32'd0);
        chk_rx("t2", 4, 8'h01);

        // 3: backpressure stops after two pops, then releases in order
        fifo_clear();
        load(8'h01, 8);
        bus.m_ready = 1'b0;
        rx_q.delete();
        en = 1'b1;
        tick();
        en = 1'b0;
        chk("t3_rd1", 32'(bus.fifo_rd), 32'd1);
        tick();
        chk("t3_m_valid", 32'(bus.m_valid), 32'd1);
        chk("t3_m_data", 32'(bus.m_data), 32'h01);
        chk("t3_rd2", 32'(bus.fifo_rd), 32'd1);
        tick();
        chk("t3_rd_hold", 32'(bus.fifo_rd), 32'd0);
        chk("t3_rd_count", 32'(rd_count), 32'd6);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_rd_hold", 32'(bus.fifo_rd), 32'd0);
            chk("t3_data_hold", 32'(bus.m_data), 32'h01);
        end
        bus.m_ready = 1'b1;
        wait_done("t3");
        chk("t3_rd_count_end", 32'(rd_count), 32'd8);
        chk_rx("t3", 4, 8'h01);

        // 4: flush drains past the burst length; flush dropped mid-burst
        fifo_clear();
        load(8'hA1, 6);
        bus.fifo_threshold = 1'b0;
        flush = 1'b1;
        rx_q.delete();
        pbase = pop_cnt;
        dbase = done_cnt;
        en = 1'b1;
        tick();
        en = 1'b0;
        flush = 1'b0;
        wait_done("t4");
        chk("t4_pops", 32'(pop_cnt - pbase), 32'd6);
        chk("t4_done_once", 32'(done_cnt - dbase), 32'd1);
        chk("t4_empty", 32'(bus.fifo_empty), 32'd1);
        chk("t4_rd_count", 32'(rd_count), 32'd14);
        chk_rx("t4", 6, 8'hA1);

        // 5: short burst ends on empty; empty FIFO never triggers
        fifo_clear();
        load(8'hB1, 2);
        bus.fifo_threshold = 1'b1;
        rx_q.delete();
        pbase = pop_cnt;
        dbase = done_cnt;
        en = 1'b1;
        tick();
        en = 1'b0;
        wait_done("t5");
        chk("t5_pops", 32'(pop_cnt - pbase), 32'd2);
        chk("t5_rd_count", 32'(rd_count), 32'd16);
        chk_rx("t5", 2, 8'hB1);
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_empty_busy", 32'(busy), 32'd0);
            chk("t5_empty_rd", 32'(bus.fifo_rd), 32'd0);
        end
        en = 1'b0;
        chk("t5_done_once", 32'(done_cnt - dbase), 32'd1);

        // 6: reset after the second pop, then a fresh burst
        fifo_clear();
        load(8'hC1, 8);
        bus.m_ready = 1'b0;
        en = 1'b1;
        tick();
        en = 1'b0;
        tick();
        tick();
        chk("t6_rd_count_pre", 32'(rd_count), 32'd18);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_m_valid", 32'(bus.m_valid), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_rd_count", 32'(rd_count), 32'd0);
        chk("t6_fifo_rd", 32'(bus.fifo_rd), 32'd0);
        tick();
        rst_n = 1'b1;
        fifo_clear();
        load(8'hD1, 4);
        bus.m_ready = 1'b1;
        rx_q.delete();
        en = 1'b1;
        tick();
        en = 1'b0;
        wait_done("t6");
        chk("t6_rd_count_new", 32'(rd_count), 32'd4);
        chk_rx("t6", 4, 8'hD1);

        chk("no_underflow", 32'(underflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
